// File: rtl/clkrst_seq_if.sv
// Board-side signal bundle for clkrst_seq: button and trap in, system clock/reset out.
interface clkrst_seq_if #(
  parameter int TRAPW = 8
);
  logic             btn_n;
  logic             trap;
  logic             clk_div;
  logic             clk_en;
  logic             system_reset;
  logic             halted;
  logic [TRAPW-1:0] trap_count;

  // master: the clock/reset sequencer
  modport master (
    input  btn_n, trap,
    output clk_div, clk_en, system_reset, halted, trap_count
  );

  // slave: the board/system side
  modport slave (
    output btn_n, trap,
    input  clk_div, clk_en, system_reset, halted, trap_count
  );
endinterface

// File: rtl/clkrst_seq.sv
// Clock divider, debounced soft reset and trap-driven reset sequencer for the board top.
module clkrst_seq #(
  parameter int CLKDIV     = 6,
  parameter int RESET_HOLD = 16,
  parameter int DEBOUNCE   = 1024,
  parameter int TRAP_MODE  = 0,
  parameter int TRAPW      = 8
) (
  input  logic          clk,
  input  logic          power_on_reset_n,
  clkrst_seq_if.master  sys
);

  if (CLKDIV < 2 || CLKDIV > 255) begin : g_bad_clkdiv
    $error("clkrst_seq: CLKDIV must be in 2..255");
  end
  if (RESET_HOLD < 1) begin : g_bad_hold
    $error("clkrst_seq: RESET_HOLD must be >= 1");
  end
  if (DEBOUNCE < 2) begin : g_bad_debounce
    $error("clkrst_seq: DEBOUNCE must be >= 2");
  end
  if (TRAP_MODE != 0 && TRAP_MODE != 1) begin : g_bad_mode
    $error("clkrst_seq: TRAP_MODE must be 0 or 1");
  end

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int DW = $clog2(DEBOUNCE);

  localparam logic [7:0]    DIV_LAST     = 8'(CLKDIV - 1);
  localparam logic [7:0]    DIV_HALF     = 8'(CLKDIV / 2);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(RESET_HOLD - 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE - 1);
  localparam bit            AUTO_RESTART = (TRAP_MODE == 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t           state;
  logic [7:0]       div_cnt;
  logic [7:0]       div_nx;
  logic [HW-1:0]    hold_cnt;
  logic [1:0]       btn_sync;
  logic [DW-1:0]    deb_cnt;
  logic             btn_pressed;
  logic             press_evt;
  logic             clk_div_q;
  logic             clk_en_q;
  logic             system_reset_q;
  logic             halted_q;
  logic [TRAPW-1:0] trap_count_q;

  assign sys.clk_div      = clk_div_q;
  assign sys.clk_en       = clk_en_q;
  assign sys.system_reset = system_reset_q;
  assign sys.halted       = halted_q;
  assign sys.trap_count   = trap_count_q;

  // Free-running divider successor value; wraps after CLKDIV-1.
  always_comb begin
    div_nx = (div_cnt == DIV_LAST) ? '0 : div_cnt + 8'd1;
  end

  // Synchronise the button, accept a level only after DEBOUNCE stable cycles, flag presses.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      btn_sync    <= 2'b11;
      deb_cnt     <= '0;
      btn_pressed <= 1'b0;
      press_evt   <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[0], sys.btn_n};
      press_evt <= 1'b0;
      if (btn_sync[1] == ~btn_pressed) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt     <= '0;
        btn_pressed <= ~btn_sync[1];
        press_evt   <= ~btn_sync[1];
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Sequencer FSM with the divider folded in, since HALT freezes it and exit restarts it.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state          <= ST_HOLD;
      hold_cnt       <= '0;
      div_cnt        <= '0;
      clk_div_q      <= 1'b0;
      clk_en_q       <= 1'b0;
      system_reset_q <= 1'b1;
      halted_q       <= 1'b0;
      trap_count_q   <= '0;
    end else begin
      // Default: divider advances; outputs track the value div_cnt is about to take.
      div_cnt   <= div_nx;
      clk_en_q  <= (div_nx == DIV_LAST);
      clk_div_q <= (div_nx < DIV_HALF);

      if (press_evt) begin
        // A press outranks a trap sampled in the same cycle, which goes uncounted.
        state          <= ST_HOLD;
        hold_cnt       <= '0;
        system_reset_q <= 1'b1;
        halted_q       <= 1'b0;
        if (state == ST_HALT) begin
          div_cnt   <= '0;
          clk_en_q  <= 1'b0;
          clk_div_q <= 1'b1;
        end
      end else begin
        case (state)
          ST_HOLD: begin
            system_reset_q <= 1'b1;
            if (btn_pressed) begin
              hold_cnt <= '0;
            end else if (clk_en_q) begin
              if (hold_cnt == HOLD_LAST) begin
                state          <= ST_RUN;
                hold_cnt       <= '0;
                system_reset_q <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (clk_en_q && sys.trap) begin
              if (trap_count_q != '1) begin
                trap_count_q <= trap_count_q + 1'b1;
              end
              if (AUTO_RESTART) begin
                state          <= ST_HOLD;
                hold_cnt       <= '0;
                system_reset_q <= 1'b1;
              end else begin
                state     <= ST_HALT;
                halted_q  <= 1'b1;
                div_cnt   <= '0;
                clk_en_q  <= 1'b0;
                clk_div_q <= 1'b0;
              end
            end
          end
          ST_HALT: begin
            div_cnt   <= div_cnt;
            clk_en_q  <= 1'b0;
            clk_div_q <= 1'b0;
          end
          default: begin
            state <= ST_HOLD;
          end
        endcase
      end
    end
  end

endmodule
